// File: rtl/vaf_555_sequencer.sv
// Controller for the on-die 555 timer macro: resets, arms and triggers the
// timer, then measures its output (pulse width or period) in clk cycles.
module vaf_555_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRIG_W      = 4,
  parameter int unsigned ARM_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             mode,
  input  logic             tmr_out,
  output logic             tmr_rst_n,
  output logic             trig_n,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] meas
);

  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_CYC - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_W - 1);
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    TRIG    = 3'd2,
    WAIT_HI = 3'd3,
    MEAS    = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mode_q, mode_nxt;
  logic [CNT_W-1:0] meas_nxt;
  logic             timeout_nxt;
  logic             tmr_rst_n_nxt, trig_n_nxt, busy_nxt, done_nxt;

  logic [1:0] sync_q;
  logic       s, s_d;
  logic       rise, fall, meas_edge;

  assign s    = sync_q[1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  // Mode 0 ends on the falling edge (width), mode 1 on the next rise (period).
  assign meas_edge = mode_q ? rise : fall;

  // Two-flop synchroniser plus edge-detect delay for the asynchronous comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], tmr_out};
      s_d    <= s;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      meas      <= '0;
      timeout   <= 1'b0;
      tmr_rst_n <= 1'b0;
      trig_n    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mode_q    <= mode_nxt;
      meas      <= meas_nxt;
      timeout   <= timeout_nxt;
      tmr_rst_n <= tmr_rst_n_nxt;
      trig_n    <= trig_n_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state, counter and result logic; outputs decode the next state.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mode_nxt    = mode_q;
    meas_nxt    = meas;
    timeout_nxt = timeout;

    unique case (state)
      IDLE: begin
        if (start && ena) begin
          mode_nxt    = mode;
          timeout_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = ARM;
        end
      end
      ARM: begin
        if (cnt == ARM_LAST) begin
          cnt_nxt   = '0;
          state_nxt = mode_q ? WAIT_HI : TRIG;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      TRIG: begin
        if (cnt == TRIG_LAST) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_HI;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (rise) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = MEAS;
        end else if (cnt == TO_VAL) begin
          timeout_nxt = 1'b1;
          meas_nxt    = '0;
          state_nxt   = FIN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      MEAS: begin
        if (meas_edge) begin
          meas_nxt  = cnt;
          state_nxt = FIN;
        end else if (cnt == TO_VAL) begin
          timeout_nxt = 1'b1;
          meas_nxt    = TO_VAL;
          state_nxt   = FIN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Dropping ena abandons the run without touching the result registers.
    if (state != IDLE && !ena) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      meas_nxt    = meas;
      timeout_nxt = timeout;
    end

    busy_nxt      = (state_nxt != IDLE);
    tmr_rst_n_nxt = (state_nxt == ARM) || (state_nxt == TRIG) ||
                    (state_nxt == WAIT_HI) || (state_nxt == MEAS);
    trig_n_nxt    = (state_nxt != TRIG);
    done_nxt      = (state_nxt == FIN);
  end

endmodule

// File: tb/tb_vaf_555_sequencer.sv
// Bench for vaf_555_sequencer: directed runs against an event-time model.
module tb_vaf_555_sequencer;

  localparam int ARM = 8;
  localparam int TRG = 4;
  localparam int TO  = 200;
  localparam int INF = 1000000;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, mode, tmr_out;
  logic        tmr_rst_n, trig_n, busy, done, timeout;
  logic [15:0] meas;

  vaf_555_sequencer #(
    .CNT_W(16), .TRIG_W(TRG), .ARM_CYC(ARM), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
    .tmr_out(tmr_out), .tmr_rst_n(tmr_rst_n), .trig_n(trig_n),
    .busy(busy), .done(done), .timeout(timeout), .meas(meas)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model of one run as edge numbers: t0 = edge that accepts start,
  // p_fin = edge entering FIN (or abort edge), p_end = edge back in IDLE.
  int          p_t0 = INF, p_fin = INF, p_end = INF;
  bit          p_mode = 1'b0, p_abort = 1'b0, p_to = 1'b0;
  logic [15:0] p_meas = '0, m_prev = '0;
  bit          to_prev = 1'b0;
  bit          model_en = 1'b0;

  int done_cnt, done_cyc, trig_lo_cnt, first_lo, start_cyc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  // Fold the finished run into the carried-over result, then request a new run.
  task automatic begin_txn(input bit m);
    if (p_t0 != INF) begin
      if (!p_abort && p_fin != INF) begin
        m_prev  = p_meas;
        to_prev = p_to;
      end else begin
        to_prev = 1'b0;
      end
    end
    mode        = m;
    start       = 1'b1;
    start_cyc   = cyc;
    p_t0        = cyc + 1;
    p_mode      = m;
    p_fin       = INF;
    p_end       = INF;
    p_abort     = 1'b0;
    done_cnt    = 0;
    done_cyc    = -1;
    trig_lo_cnt = 0;
    first_lo    = -1;
    tick();
    start = 1'b0;
  endtask

  function automatic int wait_hi_edge();
    return p_t0 + ARM + (p_mode ? 0 : TRG);
  endfunction

  // Per-cycle compare of every output against the event-time model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!trig_n) begin
        trig_lo_cnt++;
        if (first_lo < 0) first_lo = cyc;
      end
    end
    if (model_en && rst_n) begin
      bit          started, e_busy, e_rst, e_trig_n, e_done, e_to;
      logic [15:0] e_meas;
      started  = (cyc >= p_t0);
      e_busy   = started && (cyc < p_end);
      e_rst    = started && (cyc < p_fin);
      e_trig_n = !(started && !p_mode && cyc >= p_t0 + ARM &&
                   cyc < p_t0 + ARM + TRG && cyc < p_fin);
      e_done   = !p_abort && (cyc == p_fin);
      e_meas   = (!p_abort && cyc >= p_fin) ? p_meas : m_prev;
      if (!started)                  e_to = to_prev;
      else if (p_abort || cyc < p_fin) e_to = 1'b0;
      else                           e_to = p_to;
      chk("busy",      busy,      e_busy);
      chk("tmr_rst_n", tmr_rst_n, e_rst);
      chk("trig_n",    trig_n,    e_trig_n);
      chk("done",      done,      e_done);
      chk("timeout",   timeout,   e_to);
      chk("meas",      meas,      e_meas);
    end
  end

  initial begin
    int a;
    rst_n   = 1'b0;
    ena     = 1'b1;
    start   = 1'b0;
    mode    = 1'b0;
    tmr_out = 1'b0;
    tick(3);
    chk("rst_tmr_rst_n", tmr_rst_n, 0);
    chk("rst_trig_n",    trig_n,    1);
    chk("rst_busy",      busy,      0);
    chk("rst_meas",      meas,      0);
    rst_n = 1'b1;
    tick(2);
    model_en = 1'b1;

    // Mode 0: 100-cycle high pulse.
    begin_txn(1'b0);
    tick_to(wait_hi_edge());
    a = cyc;
    tmr_out = 1'b1;
    p_fin = a + 103; p_end = p_fin + 1; p_meas = 16'd100; p_to = 1'b0;
    tick(100);
    tmr_out = 1'b0;
    tick(10);
    chk("m0_meas",        meas,                  100);
    chk("m0_timeout",     timeout,               0);
    chk("m0_done_pulses", done_cnt,              1);
    chk("m0_trig_width",  trig_lo_cnt,           4);
    chk("m0_start2trig",  first_lo - start_cyc,  9);

    // Asynchronous reset in the middle of a measurement.
    begin_txn(1'b0);
    tick_to(wait_hi_edge());
    tmr_out = 1'b1;
    tick(30);
    model_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_tmr_rst_n", tmr_rst_n, 0);
    chk("arst_trig_n",    trig_n,    1);
    chk("arst_busy",      busy,      0);
    chk("arst_done",      done,      0);
    chk("arst_timeout",   timeout,   0);
    chk("arst_meas",      meas,      0);
    tmr_out = 1'b0;
    tick(2);
    chk("arst_busy_held", busy, 0);
    rst_n = 1'b1;
    p_t0 = INF; p_fin = INF; p_end = INF; p_abort = 1'b0;
    m_prev = '0; to_prev = 1'b0;
    model_en = 1'b1;
    tick(4);

    // Mode 1: square wave, period 50 (30 high / 20 low).
    begin_txn(1'b1);
    tick_to(wait_hi_edge() + 2);
    a = cyc;
    p_fin = a + 53; p_end = p_fin + 1; p_meas = 16'd50; p_to = 1'b0;
    for (int k = 0; k < 120; k++) begin
      tmr_out = ((k % 50) < 30);
      tick();
    end
    tmr_out = 1'b0;
    tick(5);
    chk("m1_meas",        meas,      50);
    chk("m1_done_pulses", done_cnt,  1);
    chk("m1_trig_pulses", trig_lo_cnt, 0);
    chk("m1_tmr_rst_n",   tmr_rst_n, 0);

    // Timeout in WAIT_HI: output stuck low.
    begin_txn(1'b0);
    p_fin = wait_hi_edge() + TO + 1; p_end = p_fin + 1; p_meas = 16'd0; p_to = 1'b1;
    tick(230);
    chk("towh_timeout", timeout,          1);
    chk("towh_meas",    meas,             0);
    chk("towh_done",    done_cnt,         1);
    chk("towh_when",    done_cyc - p_t0,  213);

    // Timeout in MEAS: output stuck high.
    begin_txn(1'b0);
    tick_to(wait_hi_edge());
    a = cyc;
    tmr_out = 1'b1;
    p_fin = a + 203; p_end = p_fin + 1; p_meas = 16'd200; p_to = 1'b1;
    tick(210);
    tmr_out = 1'b0;
    tick(5);
    chk("tom_timeout", timeout, 1);
    chk("tom_meas",    meas,    200);

    // A good run clears the sticky timeout at acceptance.
    begin_txn(1'b0);
    chk("clr_timeout", timeout, 0);
    tick_to(wait_hi_edge());
    a = cyc;
    tmr_out = 1'b1;
    p_fin = a + 10; p_end = p_fin + 1; p_meas = 16'd7; p_to = 1'b0;
    tick(7);
    tmr_out = 1'b0;
    tick(8);
    chk("short_meas",    meas,    7);
    chk("short_timeout", timeout, 0);

    // start during MEAS is ignored; ena low aborts without a result.
    begin_txn(1'b0);
    tick_to(wait_hi_edge());
    a = cyc;
    tmr_out = 1'b1;
    tick(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_to(a + 40);
    ena = 1'b0;
    p_abort = 1'b1; p_fin = cyc + 1; p_end = cyc + 1;
    tick(3);
    ena = 1'b1;
    tmr_out = 1'b0;
    tick(5);
    chk("abort_done",    done_cnt, 0);
    chk("abort_meas",    meas,     7);
    chk("abort_busy",    busy,     0);
    chk("abort_timeout", timeout,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
